// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register indices, exception codes and SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

endpackage

// File: rtl/cp0_ctrl_if.sv
// Pipeline-to-CP0 signal bundle; the pipeline is the master, CP0 the slave.
interface cp0_ctrl_if;
    logic [4:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] HandlerAddr;

    modport master (
        output Addr, WE, Din, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Dout, Req, EPCOut, HandlerAddr
    );

    modport slave (
        input  Addr, WE, Din, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Dout, Req, EPCOut, HandlerAddr
    );
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception arbitration and victim PC capture.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h0000_2020,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    cp0_ctrl_if.slave   bus
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic [5:0]  w_pend;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_victim;
    logic [31:0] w_dout;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_pend
            assign w_pend[gi] = bus.HWInt[gi] & r_im[gi];
        end
    endgenerate

    // Requests are masked by the registered SR, so a same-cycle mtc0 never affects Req.
    assign w_int_req = (|w_pend) & r_ie & ~r_exl;
    assign w_exc_req = (bus.ExcCodeIn != EXC_INT) & ~r_exl;
    assign w_req     = w_int_req | w_exc_req;
    assign w_victim  = bus.BDIn ? (bus.PC - 32'd4) : bus.PC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_req) begin
                // The faulting instruction does not commit, so any mtc0 is dropped.
                r_exl     <= 1'b1;
                r_exccode <= w_int_req ? EXC_INT : bus.ExcCodeIn;
                r_bd      <= bus.BDIn;
                r_epc     <= {w_victim[31:2], 2'b00};
            end else begin
                if (bus.WE && bus.Addr == REG_SR) begin
                    r_im  <= bus.Din[IM_HI:IM_LO];
                    r_ie  <= bus.Din[IE_BIT];
                    r_exl <= bus.EXLClr ? 1'b0 : bus.Din[EXL_BIT];
                end else if (bus.EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (bus.WE && bus.Addr == REG_EPC) begin
                    r_epc <= {bus.Din[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        w_dout = '0;
        case (bus.Addr)
            REG_SR: begin
                w_dout[IM_HI:IM_LO] = r_im;
                w_dout[EXL_BIT]     = r_exl;
                w_dout[IE_BIT]      = r_ie;
            end
            REG_CAUSE: begin
                w_dout[BD_BIT]        = r_bd;
                w_dout[IM_HI:IM_LO]   = r_ip;
                w_dout[EXC_HI:EXC_LO] = r_exccode;
            end
            REG_EPC:  w_dout = r_epc;
            REG_PRID: w_dout = PRID;
            default:  w_dout = '0;
        endcase
    end

    assign bus.Dout        = w_dout;
    assign bus.Req         = w_req;
    assign bus.EPCOut      = r_epc;
    assign bus.HandlerAddr = HANDLER;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: a register-level model checked every cycle plus literal expectations.
module tb_cp0_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    cp0_ctrl_if bus();

    cp0_ctrl #(
        .PRID    (32'h0000_2020),
        .HANDLER (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model holds whole architectural words; reads are masks of those words.
    logic [31:0] m_sr, m_cause, m_epc;
    bit          m_valid = 0;

    function automatic bit mdl_int();
        return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit mdl_req();
        return mdl_int() || ((bus.ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr & 32'h0000_FC03;
            5'd13:   return m_cause & 32'h8000_FC7C;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_2020;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit          take, is_int;
        logic [31:0] victim;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_valid = 1;
        end else if (m_valid) begin
            take   = mdl_req();
            is_int = mdl_int();
            victim = bus.BDIn ? bus.PC - 32'd4 : bus.PC;
            m_cause[15:10] = bus.HWInt;
            if (take) begin
                m_sr[1]       = 1'b1;
                m_cause[6:2]  = is_int ? 5'd0 : bus.ExcCodeIn;
                m_cause[31]   = bus.BDIn;
                m_epc         = victim & 32'hFFFF_FFFC;
            end else begin
                if (bus.WE && bus.Addr == 5'd12) m_sr = bus.Din & 32'h0000_FC03;
                if (bus.WE && bus.Addr == 5'd14) m_epc = bus.Din & 32'hFFFF_FFFC;
                if (bus.EXLClr) m_sr[1] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("mdl_req",     {31'd0, bus.Req}, {31'd0, mdl_req()});
            check("mdl_dout",    bus.Dout, mdl_read(bus.Addr));
            check("mdl_epcout",  bus.EPCOut, m_epc);
            check("mdl_handler", bus.HandlerAddr, 32'h0000_4180);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.Addr = 0; bus.WE = 0; bus.Din = 0; bus.PC = 0; bus.BDIn = 0;
        bus.ExcCodeIn = 0; bus.HWInt = 0; bus.EXLClr = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; bus.Addr = 5'd12;
        at_neg(); check("rst_sr", bus.Dout, 32'h0); check("rst_req", {31'd0, bus.Req}, 32'd0);
        cyc(); bus.Addr = 5'd13;
        at_neg(); check("rst_cause", bus.Dout, 32'h0);
        cyc(); bus.Addr = 5'd14;
        at_neg(); check("rst_epc", bus.Dout, 32'h0); check("rst_epcout", bus.EPCOut, 32'h0);
        cyc(); bus.Addr = 5'd15; bus.HWInt = 6'b111111;
        at_neg(); check("prid", bus.Dout, 32'h0000_2020);
        check("rst_req_hw", {31'd0, bus.Req}, 32'd0);
        check("handler", bus.HandlerAddr, 32'h0000_4180);
        cyc(); bus.HWInt = 0; bus.Addr = 5'd13;
        at_neg(); check("ip_latency", bus.Dout, 32'h0000_FC00);

        // Interrupt path
        cyc(); bus.Addr = 5'd12; bus.WE = 1; bus.Din = 32'h0000_0401;
        cyc(); bus.WE = 0;
        at_neg(); check("sr_write", bus.Dout, 32'h0000_0401);
        cyc(); bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010;
        at_neg(); check("int_req", {31'd0, bus.Req}, 32'd1);
        cyc(); bus.Addr = 5'd13;
        at_neg(); check("int_cause", bus.Dout, 32'h0000_0400);
        check("int_epc", bus.EPCOut, 32'h0000_3010);
        check("int_masked", {31'd0, bus.Req}, 32'd0);
        cyc(); bus.HWInt = 0; bus.Addr = 5'd12;
        at_neg(); check("int_exl", bus.Dout, 32'h0000_0403);

        // Exception in delay slot with IE=0
        cyc(); bus.WE = 1; bus.Din = 32'h0000_0400;
        cyc(); bus.WE = 0; bus.ExcCodeIn = 5'd12; bus.PC = 32'h0000_3024; bus.BDIn = 1;
        at_neg(); check("ov_req", {31'd0, bus.Req}, 32'd1);
        cyc(); bus.ExcCodeIn = 0; bus.BDIn = 0; bus.Addr = 5'd13;
        at_neg(); check("ov_cause", bus.Dout, 32'h8000_0030);
        check("ov_epc", bus.EPCOut, 32'h0000_3020);

        // Masking under EXL, then eret releases a pending interrupt
        cyc(); bus.Addr = 5'd12; bus.WE = 1; bus.Din = 32'h0000_0403;
        cyc(); bus.WE = 0; bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd4; bus.PC = 32'h0000_3040;
        at_neg(); check("exl_mask", {31'd0, bus.Req}, 32'd0);
        check("exl_sr", bus.Dout, 32'h0000_0403);
        cyc(); bus.EXLClr = 1;
        at_neg(); check("eret_req", {31'd0, bus.Req}, 32'd0);
        cyc(); bus.EXLClr = 0;
        at_neg(); check("post_eret_req", {31'd0, bus.Req}, 32'd1);
        cyc(); bus.HWInt = 0; bus.ExcCodeIn = 0; bus.Addr = 5'd13;
        at_neg(); check("prio_cause", bus.Dout, 32'h0000_0400);
        check("prio_epc", bus.EPCOut, 32'h0000_3040);

        // EPC writes, EXLClr vs SR write, write dropped under Req
        cyc(); bus.Addr = 5'd14; bus.WE = 1; bus.Din = 32'h0000_3007;
        cyc(); bus.WE = 0;
        at_neg(); check("epc_align", bus.Dout, 32'h0000_3004);
        cyc(); bus.Addr = 5'd12; bus.WE = 1; bus.Din = 32'h0000_0403; bus.EXLClr = 1;
        cyc(); bus.WE = 0; bus.EXLClr = 0;
        at_neg(); check("eret_wins", bus.Dout, 32'h0000_0401);
        cyc(); bus.Addr = 5'd14; bus.WE = 1; bus.Din = 32'h0000_5557;
        bus.ExcCodeIn = 5'd10; bus.PC = 32'h0000_3100;
        at_neg(); check("ri_req", {31'd0, bus.Req}, 32'd1);
        cyc(); bus.WE = 0; bus.ExcCodeIn = 0;
        at_neg(); check("we_dropped", bus.Dout, 32'h0000_3100);

        // Reset mid-handler
        cyc(); reset = 1; bus.HWInt = 6'b000001;
        cyc(); reset = 0; bus.Addr = 5'd12;
        at_neg(); check("mid_rst_sr", bus.Dout, 32'h0);
        check("mid_rst_epc", bus.EPCOut, 32'h0);
        check("mid_rst_req", {31'd0, bus.Req}, 32'd0);
        cyc(); bus.Addr = 5'd13;
        at_neg(); check("mid_rst_ip", bus.Dout, 32'h0000_0400);

        // Unmapped register
        cyc(); bus.HWInt = 0; bus.Addr = 5'd5; bus.WE = 1; bus.Din = 32'hFFFF_FFFF;
        cyc(); bus.WE = 0;
        at_neg(); check("unmapped", bus.Dout, 32'h0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
